// File: rtl/noc_tree_pkg.sv
// Shared definitions for the tree NoC router: packet layout and arbiter state encoding.
package noc_tree_pkg;

  localparam int unsigned WIDTH_addr    = 3;
  localparam int unsigned WIDTH_dest    = 3;
  localparam int unsigned WIDTH_packet  = 14;
  localparam int unsigned WIDTH_payload = WIDTH_packet - WIDTH_addr - WIDTH_dest;

  // Field order from MSB: addr, dest, payload.
  typedef struct packed {
    logic [WIDTH_addr-1:0]    addr;
    logic [WIDTH_dest-1:0]    dest;
    logic [WIDTH_payload-1:0] payload;
  } packet_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head is read straight from storage (no bypass).
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tree_out_arbiter.sv
// Output-port merge stage: round-robin arbitration between two input controllers
// feeding a small FIFO toward the next hop.
module tree_out_arbiter
  import noc_tree_pkg::*;
#(
  parameter int unsigned WIDTH_packet = noc_tree_pkg::WIDTH_packet,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [WIDTH_packet-1:0] in0_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [WIDTH_packet-1:0] in1_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_packet-1:0] out_data,
  output logic [CNT_W-1:0]        count
);

  rr_state_e               rr_q, rr_d;
  logic                    full;
  logic                    empty;
  logic                    grant0;
  logic                    grant1;
  logic                    push;
  logic                    pop;
  logic [WIDTH_packet-1:0] push_data;

  // Grant derives from registered occupancy, so a same-cycle pop cannot free a slot early.
  assign grant0    = !rst && !full && in0_valid && (!in1_valid || (rr_q == PRI0));
  assign grant1    = !rst && !full && in1_valid && (!in0_valid || (rr_q == PRI1));
  assign in0_ready = grant0;
  assign in1_ready = grant1;
  assign push      = grant0 || grant1;
  assign push_data = grant1 ? in1_data : in0_data;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rr_d = rr_q;
    if (grant0)      rr_d = PRI1;
    else if (grant1) rr_d = PRI0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= PRI0;
    else     rr_q <= rr_d;
  end

  noc_sync_fifo #(
    .WIDTH (WIDTH_packet),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_no_ready_full: assert property (@(posedge clk) disable iff (rst) full |-> !(in0_ready || in1_ready));
  a_single_grant: assert property (@(posedge clk) !(in0_ready && in1_ready));

endmodule

// File: tb/tb_tree_out_arbiter.sv
// Directed scoreboard bench for tree_out_arbiter: stimulus queues drive the inputs,
// a negedge monitor checks every popped packet against the expected-output queue.
module tb_tree_out_arbiter;

  localparam int unsigned W     = 14;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in0_valid, in0_ready;
  logic [W-1:0]     in0_data;
  logic             in1_valid, in1_ready;
  logic [W-1:0]     in1_data;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] src0[$];
  logic [W-1:0] src1[$];
  logic [W-1:0] exp_q[$];
  int           acc_log[$];
  int           acc_cyc[$];
  int           pop_cyc[$];
  logic         f0, f1;

  tree_out_arbiter #(.WIDTH_packet(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input driver: holds each source head valid until the transfer is seen.
  initial begin
    in0_valid = 1'b0; in0_data = '0;
    in1_valid = 1'b0; in1_data = '0;
    forever begin
      @(negedge clk);
      f0 = in0_valid && in0_ready;
      f1 = in1_valid && in1_ready;
      if (f0) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
      if (f1) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
      @(posedge clk);
      #1;
      if (f0) void'(src0.pop_front());
      if (f1) void'(src1.pop_front());
      in0_valid = (src0.size() != 0);
      in0_data  = in0_valid ? src0[0] : '0;
      in1_valid = (src1.size() != 0);
      in1_data  = in1_valid ? src1[0] : '0;
    end
  end

  // Output monitor: every pop must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Bit i of exp is the input index expected for the i-th accepted packet.
  task automatic check_grants(input string name, input int n, input logic [15:0] exp);
    check({name, "_n"}, 32'(acc_log.size()), 32'(n));
    for (int i = 0; i < n && i < acc_log.size(); i++)
      check(name, 32'(acc_log[i]), 32'(exp[i]));
  endtask

  task automatic check_contig(input string name);
    for (int i = 1; i < acc_cyc.size(); i++)
      check(name, 32'(acc_cyc[i]), 32'(acc_cyc[i-1] + 1));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    cycles(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    cycles(1);

    // Reset mid-stream: two in0 packets buffered (rr moves to PRI1), then reset.
    clear_logs();
    src0.push_back(14'h0011);
    src0.push_back(14'h0012);
    cycles(5);
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check_grants("pre_rst_grant", 2, 16'h0);
    rst = 1'b1;
    cycles(1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    clear_logs();
    out_ready = 1'b1;
    src0.push_back(14'h0101); exp_q.push_back(14'h0101);
    src1.push_back(14'h0202); exp_q.push_back(14'h0202);
    cycles(1);
    check("post_rst_in0_ready", 32'(in0_ready), 32'd1);
    check("post_rst_in1_ready", 32'(in1_ready), 32'd0);
    drain("post_rst_drain", 20);
    check_grants("post_rst_grant", 2, 16'h2);

    // Single stream on in0: one per cycle, latency 1.
    clear_logs();
    src0.push_back(14'h01A5); exp_q.push_back(14'h01A5);
    src0.push_back(14'h02B6); exp_q.push_back(14'h02B6);
    src0.push_back(14'h03C7); exp_q.push_back(14'h03C7);
    cycles(2);
    check("single_count", 32'(count), 32'd1);
    check("single_in1_ready", 32'(in1_ready), 32'd0);
    check("single_out_valid", 32'(out_valid), 32'd1);
    drain("single_drain", 20);
    check_grants("single_grant", 3, 16'h0);
    check_contig("single_contig");
    check("single_npop", 32'(pop_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < pop_cyc.size() && i < acc_cyc.size(); i++)
      check("single_latency", 32'(pop_cyc[i]), 32'(acc_cyc[i] + 1));

    // Contention: rr is PRI1 after the in0 stream, so in1 leads.
    clear_logs();
    src0.push_back(14'h00AA); src0.push_back(14'h00AB); src0.push_back(14'h00AC);
    src1.push_back(14'h0155); src1.push_back(14'h0156);
    src1.push_back(14'h0157); src1.push_back(14'h0158);
    exp_q.push_back(14'h0155); exp_q.push_back(14'h00AA);
    exp_q.push_back(14'h0156); exp_q.push_back(14'h00AB);
    exp_q.push_back(14'h0157); exp_q.push_back(14'h00AC);
    exp_q.push_back(14'h0158);
    drain("contend_drain", 30);
    check_grants("contend_grant", 7, 16'h0055);
    check_contig("contend_contig");

    // Backpressure until full, then a single pop while full.
    clear_logs();
    out_ready = 1'b0;
    src0.push_back(14'h00D0); src0.push_back(14'h00D1);
    src1.push_back(14'h00E0); src1.push_back(14'h00E1);
    exp_q.push_back(14'h00D0); exp_q.push_back(14'h00E0);
    exp_q.push_back(14'h00D1); exp_q.push_back(14'h00E1);
    cycles(5);
    check("full_count", 32'(count), 32'd2);
    check("full_in0_ready", 32'(in0_ready), 32'd0);
    check("full_in1_ready", 32'(in1_ready), 32'd0);
    check("full_head", 32'(out_data), 32'h00D0);
    out_ready = 1'b1;
    #2;
    check("full_pop_in0_ready", 32'(in0_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #1;
    check("after_pop_count", 32'(count), 32'd1);
    check("after_pop_in0_ready", 32'(in0_ready), 32'd1);
    check("after_pop_in1_ready", 32'(in1_ready), 32'd0);
    check("after_pop_head", 32'(out_data), 32'h00E0);
    cycles(1);
    check("refill_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    drain("full_drain", 20);
    check_grants("full_grant", 4, 16'h000A);

    // Simultaneous push and pop at count 1.
    clear_logs();
    out_ready = 1'b0;
    src0.push_back(14'h03F0);
    exp_q.push_back(14'h03F0); exp_q.push_back(14'h03F1);
    cycles(3);
    check("pp_count_before", 32'(count), 32'd1);
    src0.push_back(14'h03F1);
    cycles(1);
    check("pp_in0_ready", 32'(in0_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #1;
    check("pp_count_after", 32'(count), 32'd1);
    check("pp_head", 32'(out_data), 32'h03F1);
    check("pp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain("pp_drain", 20);

    // Wrap-around: seven packets with random backpressure.
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      src0.push_back(W'(14'h2000 + i));
      exp_q.push_back(W'(14'h2000 + i));
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #2;
        n++;
      end
    end
    check("wrap_drain", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    cycles(2);
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_out_valid", 32'(out_valid), 32'd0);
    check_grants("wrap_grant", 7, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
